// File: rtl/uart_tx.sv
// UART transmitter: start bit, W data bits LSB first, optional parity, one stop bit,
// each bit held for PRESCALE clock cycles. Loop-back compatible with UART_RX.
`timescale 1ns/1ps
module uart_tx #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] P_DATA,
  input  logic         DATA_VALID,
  input  logic         PAR_EN,
  input  logic         PAR_TYP,
  input  logic [5:0]   PRESCALE,
  output logic         TX_OUT,
  output logic         BUSY,
  output logic         TX_DONE
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [5:0]    edge_cnt;
  logic [5:0]    pre_q;
  logic [BW-1:0] bit_idx;
  logic [W:0]    shreg;
  logic          par_en_q;
  logic          par_bit_q;
  logic          last_edge;
  logic          accept;

  // A request may also be taken on the final edge of a stop bit so that
  // back-to-back frames run with no idle gap on the line.
  always_comb begin
    last_edge = (edge_cnt == pre_q - 6'd1);
    accept    = DATA_VALID && (PRESCALE != '0) &&
                ((state == IDLE) || ((state == STOP) && last_edge));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      pre_q     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      TX_DONE   <= 1'b0;
    end else begin
      TX_DONE <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= last_edge ? '0 : edge_cnt + 6'd1;
      end

      if ((state != IDLE) && last_edge) begin
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            TX_OUT  <= shreg[0];
          end
          DATA: begin
            if (bit_idx == BW'(W - 1)) begin
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= par_bit_q;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              TX_OUT  <= shreg[1];
            end
          end
          PARITY: begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
          STOP: begin
            state   <= IDLE;
            BUSY    <= 1'b0;
            TX_DONE <= 1'b1;
            TX_OUT  <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
          end
        endcase
      end

      // Placed last so a chained acceptance overrides the stop-bit exit above.
      if (accept) begin
        state     <= START;
        edge_cnt  <= '0;
        bit_idx   <= '0;
        shreg     <= {1'b0, P_DATA};
        pre_q     <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
        TX_OUT    <= 1'b0;
        BUSY      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, busy/reset/prescale corner cases,
// a behavioural loop-back receiver and randomized frames against a frame model.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic       TX_OUT;
  logic       BUSY;
  logic       TX_DONE;

  int checks = 0;
  int errors = 0;

  uart_tx #(.W(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .TX_DONE    (TX_DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         pt;
    logic [5:0] pre;
    logic       exp_par;
    int         exp_busy;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] rx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of frame bit j: 0 = start, 1..8 data LSB first, then parity, then stop.
  function automatic bit exp_bit(input logic [7:0] d, input bit pe, input bit pt, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (j == 9 && pe) return bit'($countones(d) % 2) ^ pt;
    return 1'b1;
  endfunction

  // Drive a request; returns at the sample point just after the accepting edge.
  task automatic accept_frame(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] pre);
    @(negedge clk);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    PRESCALE   = pre;
    DATA_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble();
    DATA_VALID = 1'b0;
    P_DATA     = 8'($urandom);
    PAR_EN     = 1'($urandom);
    PAR_TYP    = 1'($urandom);
    PRESCALE   = 6'($urandom);
  endtask

  task automatic check_frame(input logic [7:0] d, input bit pe, input bit pt, input int pre,
                             input bit done_first, input bit chained, input string tag,
                             output int busy_n, output logic par_seen);
    int n;
    n = pe ? 11 : 10;
    busy_n = 0;
    par_seen = 1'bx;
    for (int t = 0; t < n * pre; t++) begin
      chk({tag, " tx"}, TX_OUT, exp_bit(d, pe, pt, t / pre));
      chk({tag, " done"}, TX_DONE, (t == 0 && done_first) ? 1 : 0);
      if (BUSY === 1'b1) busy_n++;
      if (pe && t == 9 * pre) par_seen = TX_OUT;
      @(negedge clk);
    end
    if (!chained) begin
      chk({tag, " end_busy"}, BUSY, 0);
      chk({tag, " end_done"}, TX_DONE, 1);
      chk({tag, " end_tx"}, TX_OUT, 1);
      @(negedge clk);
      chk({tag, " done_clr"}, TX_DONE, 0);
      chk({tag, " idle_tx"}, TX_OUT, 1);
    end
  endtask

  // Behavioural receiver: mid-bit sampling, odd parity, PRESCALE=8.
  task automatic rx_capture(input int n_words);
    logic [7:0] d;
    logic       p;
    logic       s;
    int         guard;
    for (int w = 0; w < n_words; w++) begin
      guard = 0;
      while (TX_OUT !== 1'b0 && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      chk("rx_timeout", guard >= 1000, 0);
      repeat (4) @(negedge clk);
      chk("rx_start", TX_OUT, 0);
      for (int b = 0; b < 8; b++) begin
        repeat (8) @(negedge clk);
        d[b] = TX_OUT;
      end
      repeat (8) @(negedge clk);
      p = TX_OUT;
      repeat (8) @(negedge clk);
      s = TX_OUT;
      rx_q.push_back(d);
      chk("rx_par_err", p !== ~(^d), 0);
      chk("rx_stp_err", s !== 1'b1, 0);
    end
  endtask

  initial begin
    int         busy_n;
    logic       par_seen;
    logic [7:0] exp_words[3];

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  1'bx, 80};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd16, 1'b0, 176};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd16, 1'b1, 176};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 6'd16, 1'b1, 176};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 6'd1,  1'b0, 11};
    vecs[5] = '{8'h01, 1'b0, 1'b0, 6'd63, 1'bx, 630};

    rst = 1'b1;
    DATA_VALID = 1'b0;
    P_DATA = '0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    PRESCALE = 6'd8;
    #1;
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", TX_DONE, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", BUSY, 0);

    for (int i = 0; i < 6; i++) begin
      accept_frame(vecs[i].d, vecs[i].pe, vecs[i].pt, vecs[i].pre);
      scramble();
      check_frame(vecs[i].d, vecs[i].pe, vecs[i].pt, int'(vecs[i].pre), 1'b0, 1'b0,
                  $sformatf("vec%0d", i), busy_n, par_seen);
      chk($sformatf("vec%0d busy_cycles", i), busy_n, vecs[i].exp_busy);
      if (vecs[i].pe) chk($sformatf("vec%0d parity", i), par_seen, vecs[i].exp_par);
    end

    // Busy protection: inputs change mid-frame with DATA_VALID held high.
    accept_frame(8'hC3, 1'b0, 1'b0, 6'd8);
    P_DATA = 8'h3C;
    PRESCALE = 6'd32;
    check_frame(8'hC3, 1'b0, 1'b0, 8, 1'b0, 1'b1, "busy_f1", busy_n, par_seen);
    chk("busy_f1 cycles", busy_n, 80);
    chk("busy_chain_busy", BUSY, 1);
    scramble();
    check_frame(8'h3C, 1'b0, 1'b0, 32, 1'b1, 1'b0, "busy_f2", busy_n, par_seen);
    chk("busy_f2 cycles", busy_n, 320);

    // Asynchronous reset during data bit 3.
    accept_frame(8'hA5, 1'b0, 1'b0, 6'd8);
    scramble();
    repeat (34) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst tx", TX_OUT, 1);
    chk("mid_rst busy", BUSY, 0);
    chk("mid_rst done", TX_DONE, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst hold_done", TX_DONE, 0);
      chk("mid_rst hold_busy", BUSY, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst done", TX_DONE, 0);
    accept_frame(8'h5A, 1'b0, 1'b0, 6'd8);
    scramble();
    check_frame(8'h5A, 1'b0, 1'b0, 8, 1'b0, 1'b0, "post_rst", busy_n, par_seen);
    chk("post_rst cycles", busy_n, 80);

    // PRESCALE=0 request is ignored.
    @(negedge clk);
    P_DATA = 8'hFF;
    PRESCALE = 6'd0;
    DATA_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pre0 busy", BUSY, 0);
      chk("pre0 tx", TX_OUT, 1);
    end
    DATA_VALID = 1'b0;

    // Loop-back into a behavioural receiver, back-to-back odd-parity frames.
    exp_words = '{8'h00, 8'hFF, 8'h81};
    fork
      rx_capture(3);
      begin
        accept_frame(8'h00, 1'b1, 1'b1, 6'd8);
        P_DATA = 8'hFF;
        check_frame(8'h00, 1'b1, 1'b1, 8, 1'b0, 1'b1, "lb0", busy_n, par_seen);
        P_DATA = 8'h81;
        check_frame(8'hFF, 1'b1, 1'b1, 8, 1'b1, 1'b1, "lb1", busy_n, par_seen);
        scramble();
        check_frame(8'h81, 1'b1, 1'b1, 8, 1'b1, 1'b0, "lb2", busy_n, par_seen);
      end
    join
    chk("rx_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_q.size()) chk($sformatf("rx_word%0d", i), rx_q[i], exp_words[i]);
    end

    // Randomized frames against the frame model.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      bit         pe;
      bit         pt;
      int         pre;
      d   = 8'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      pre = $urandom_range(1, 12);
      accept_frame(d, pe, pt, 6'(pre));
      scramble();
      check_frame(d, pe, pt, pre, 1'b0, 1'b0, $sformatf("rnd%0d", i), busy_n, par_seen);
      chk($sformatf("rnd%0d busy_cycles", i), busy_n, (pe ? 11 : 10) * pre);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
